// File: rtl/mem_if_pkg.sv
// Shared definitions for the 4x8 RAM initiator: default widths, FSM states
// and the strobe counter sizing.
package mem_if_pkg;

   localparam int DATA_W_DEF        = 8;
   localparam int ADDR_W_DEF        = 2;
   localparam int STROBE_CYCLES_DEF = 2;
   localparam int STRB_CNT_W        = $clog2(STROBE_CYCLES_DEF + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETUP   = 2'd1,
      STROBE  = 2'd2,
      RELEASE = 2'd3
   } state_e;

   function automatic int strb_cnt_w(input int cycles);
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/mem_access_ctrl.sv
// Initiator for the level-sensitive 4x8 RAM: single writes and wrapping read
// bursts, with address/direction only moving while the enable strobe is low.
module mem_access_ctrl
   import mem_if_pkg::*;
#(
   parameter int DATA_W        = DATA_W_DEF,
   parameter int ADDR_W        = ADDR_W_DEF,
   parameter int STROBE_CYCLES = STROBE_CYCLES_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] len,
   input  logic [DATA_W-1:0] wdata,
   output logic              busy,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata,
   output logic              done,
   output logic              mem_r_w,
   output logic              mem_oe,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int              SCW       = strb_cnt_w(STROBE_CYCLES);
   localparam logic [SCW-1:0]  STRB_LAST = SCW'(STROBE_CYCLES - 1);

   state_e              state_q, state_d;
   logic [SCW-1:0]      strb_q, strb_d;
   logic [ADDR_W-1:0]   word_q, word_d;
   logic [ADDR_W-1:0]   len_q, len_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                we_q, we_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [DATA_W-1:0]   rdata_q, rdata_d;
   logic                last_word;

   // Writes are always one word, so the burst length is forced to zero.
   assign last_word = (word_q == len_q);

   always_comb begin
      state_d = state_q;
      strb_d  = strb_q;
      word_d  = word_q;
      len_d   = len_q;
      addr_d  = addr_q;
      we_d    = we_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      case (state_q)
         IDLE: begin
            if (req) begin
               we_d    = we;
               addr_d  = addr;
               len_d   = we ? '0 : len;
               wdata_d = wdata;
               word_d  = '0;
               state_d = SETUP;
            end
         end
         SETUP: begin
            strb_d  = '0;
            state_d = STROBE;
         end
         STROBE: begin
            if (strb_q == STRB_LAST) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = RELEASE;
            end else begin
               strb_d = strb_q + 1'b1;
            end
         end
         RELEASE: begin
            if (last_word) begin
               state_d = IDLE;
            end else begin
               addr_d  = addr_q + 1'b1;
               word_d  = word_q + 1'b1;
               state_d = SETUP;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         strb_q  <= '0;
         word_q  <= '0;
         len_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         strb_q  <= strb_d;
         word_q  <= word_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         we_q    <= we_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   // Every output is a decode of registered state; nothing flows from inputs.
   assign busy      = (state_q != IDLE);
   assign mem_oe    = (state_q == STROBE);
   assign rvalid    = (state_q == RELEASE) && !we_q;
   assign done      = (state_q == RELEASE) && last_word;
   assign mem_r_w   = we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl paired with a behavioural 4x8 RAM; directed steps
// followed by random transactions scored against an array model.
module tb_mem_access_ctrl;

   logic       clk, rst_n, req, we;
   logic [1:0] addr, len;
   logic [7:0] wdata;
   logic       busy, rvalid, done, mem_r_w, mem_oe;
   logic [7:0] rdata, mem_wdata;
   logic [1:0] mem_addr;
   wire  [7:0] mem_rdata;

   mem_access_ctrl dut (
      .clk(clk), .rst_n(rst_n), .req(req), .we(we), .addr(addr), .len(len),
      .wdata(wdata), .busy(busy), .rvalid(rvalid), .rdata(rdata), .done(done),
      .mem_r_w(mem_r_w), .mem_oe(mem_oe), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // RAM block: drives data only while enabled for a read.
   logic [7:0] ram [4] = '{8'h01, 8'h03, 8'h03, 8'h04};
   assign mem_rdata = (mem_oe && !mem_r_w) ? ram[mem_addr] : 8'bz;
   always @(posedge clk) if (mem_oe && mem_r_w) ram[mem_addr] <= mem_wdata;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Observation log, filled on falling edges and only read by the main sequence.
   int       rv_n = 0, done_n = 0, done_cyc = 0, busy_n = 0, oe_n = 0, wroe_n = 0;
   int       stab_viol = 0, done_viol = 0;
   logic [7:0] rv_data [512];
   logic [1:0] rv_addr [512];
   int       rv_cyc  [512];
   bit       pending = 0, prev_oe = 0, prev_busy = 0, prev_rw = 0;
   logic [1:0] prev_addr = '0;

   always @(negedge clk) begin
      if (!rst_n) begin
         pending = 0;
      end else begin
         if (busy && !prev_busy) pending = 1;
         if (busy) busy_n++;
         if (mem_oe) begin
            oe_n++;
            if (mem_r_w) wroe_n++;
         end
         if (prev_oe && mem_oe && (mem_addr !== prev_addr || mem_r_w !== prev_rw)) stab_viol++;
         if (rvalid) begin
            rv_data[rv_n % 512] = rdata;
            rv_addr[rv_n % 512] = mem_addr;
            rv_cyc[rv_n % 512]  = cyc;
            rv_n++;
         end
         if (done) begin
            if (!pending) done_viol++;
            pending  = 0;
            done_cyc = cyc;
            done_n++;
         end
      end
      prev_oe   = mem_oe;
      prev_busy = busy;
      prev_rw   = mem_r_w;
      prev_addr = mem_addr;
   end

   int n_tests = 0, n_fail = 0;
   logic [7:0] ram_m [4];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic txn(input logic w, input logic [1:0] a, input logic [1:0] l,
                      input logic [7:0] d, input bit intrude);
      int nw, rv0, dn0, bz0, oe0, wo0, sv0, dv0, acc, idx, aa;
      bit got;
      nw  = w ? 1 : int'(l) + 1;
      aa  = int'(a);
      rv0 = rv_n; dn0 = done_n; bz0 = busy_n; oe0 = oe_n; wo0 = wroe_n;
      sv0 = stab_viol; dv0 = done_viol;
      @(negedge clk);
      req = 1'b1; we = w; addr = a; len = l; wdata = d;
      @(posedge clk); #1;
      acc = cyc;
      // Scramble inputs after acceptance; the latched request must win.
      req = 1'b0; we = 1'($urandom); addr = 2'($urandom); len = 2'($urandom); wdata = 8'($urandom);
      if (intrude) begin
         repeat (5) @(negedge clk);
         req = 1'b1; we = 1'b1; addr = 2'd1; wdata = 8'hEE;
         @(negedge clk);
         req = 1'b0;
      end
      got = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk); #1;
         if (done_n != dn0) begin got = 1; break; end
      end
      chk("done_seen", 32'(got), 32'd1);
      chk("done_count", done_n - dn0, 1);
      chk("done_cycle", done_cyc, acc + 4 * nw - 1);
      chk("busy_cycles", busy_n - bz0, 4 * nw);
      chk("oe_cycles", oe_n - oe0, 2 * nw);
      chk("write_oe_cycles", wroe_n - wo0, w ? 2 : 0);
      chk("rvalid_count", rv_n - rv0, w ? 0 : nw);
      if (w) begin
         ram_m[aa] = d;
      end else begin
         for (int i = 0; i < nw; i++) begin
            idx = (rv0 + i) % 512;
            chk("rdata", rv_data[idx], ram_m[(aa + i) % 4]);
            chk("read_addr", rv_addr[idx], (aa + i) % 4);
            if (i > 0) chk("rvalid_spacing", rv_cyc[idx] - rv_cyc[(rv0 + i - 1) % 512], 4);
            if (i == nw - 1) chk("done_with_last", done_cyc, rv_cyc[idx]);
         end
      end
      chk("stable_while_oe", stab_viol - sv0, 0);
      chk("done_after_accept", done_viol - dv0, 0);
      @(negedge clk); #1;
      chk("idle_after_done", busy, 1'b0);
   endtask

   initial begin
      int rv0, dn0;
      bit seen;
      ram_m = '{8'h01, 8'h03, 8'h03, 8'h04};
      req = 0; we = 0; addr = 0; len = 0; wdata = 0;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_done", done, 0);
      chk("rst_oe", mem_oe, 0);
      chk("rst_rw", mem_r_w, 0);
      chk("rst_addr", mem_addr, 0);
      chk("rst_wdata", mem_wdata, 0);
      chk("rst_rdata", rdata, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;

      txn(1'b0, 2'd0, 2'd3, 8'h00, 1'b0);  // full burst from 0
      txn(1'b1, 2'd2, 2'd0, 8'hA5, 1'b0);  // write then read back
      txn(1'b0, 2'd2, 2'd0, 8'h00, 1'b0);
      txn(1'b0, 2'd3, 2'd1, 8'h00, 1'b0);  // wrap 3 -> 0
      txn(1'b0, 2'd0, 2'd3, 8'h00, 1'b1);  // request during burst is dropped
      txn(1'b0, 2'd1, 2'd0, 8'h00, 1'b0);

      // Abort a read in the middle of its strobe.
      rv0 = rv_n; dn0 = done_n;
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 2'd0; len = 2'd0;
      @(posedge clk); #1 req = 1'b0;
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk); #1;
         if (mem_oe) begin seen = 1; break; end
      end
      chk("oe_before_abort", 32'(seen), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_oe", mem_oe, 0);
      chk("abort_busy", busy, 0);
      chk("abort_rw", mem_r_w, 0);
      repeat (2) @(negedge clk);
      #1 rst_n = 1'b1;
      repeat (6) @(negedge clk);
      #1;
      chk("abort_no_rvalid", rv_n - rv0, 0);
      chk("abort_no_done", done_n - dn0, 0);
      txn(1'b0, 2'd0, 2'd0, 8'h00, 1'b0);

      for (int t = 0; t < 24; t++)
         txn(1'($urandom), 2'($urandom), 2'($urandom), 8'($urandom), 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Initiator-side controller for the team's 4-word × 8-bit level-sensitive RAM block. It drives that block's interface: the read/write select, output-enable strobe, 2-bit address, write data bus and tri-stated read data bus. It gives the host a clocked request/done handshake, including single writes and 1–4 word read bursts with address wrap-around. It sits between the host-side sequencer and the RAM and guarantees setup/hold ordering, because the RAM reacts to level changes on its enable and direction inputs.

## Interface
- DATA_W, 8, data width of RAM words and host data.
- ADDR_W, 2, RAM address width; burst length field also ADDR_W bits.
- STROBE_CYCLES, 2, cycles mem_oe is held high per word (≥1).

- clk  in  1  system clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  1  host request; accepted only in IDLE.
- we  in  1  1 = single write, 0 = read burst.
- addr  in  ADDR_W  start address.
- len  in  ADDR_W  read burst length minus 1 (0..3); ignored when we=1.
- wdata  in  DATA_W  write data.
- busy  out  1  high whenever state ≠ IDLE.
- rvalid  out  1  one-cycle pulse per read word.
- rdata  out  DATA_W  read word, valid while rvalid=1 and held until the next capture.
- done  out  1  one-cycle pulse on the final RELEASE cycle of a transaction.
- mem_r_w  out  1  RAM direction, 1 = write.
- mem_oe  out  1  RAM enable strobe.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data; Z when mem_oe=0.

## Operation
- States: IDLE, SETUP, STROBE, RELEASE.
- IDLE: when req=1, latch we, addr, len and wdata into internal registers, clear the word counter, then go to SETUP. Later input changes are ignored until the next IDLE.
- SETUP (1 cycle): mem_addr = current address; mem_r_w = latched we; mem_wdata = latched wdata; mem_oe = 0.
- STROBE (STROBE_CYCLES cycles): mem_oe = 1, with mem_addr, mem_r_w and mem_wdata held stable. For reads, capture mem_rdata into rdata on the edge that ends the last STROBE cycle.
- RELEASE (1 cycle): mem_oe = 0, with address, direction and data still held. rvalid = 1 for reads.
  - If words remain: address increments modulo 2^ADDR_W (3 wraps to 0), counter increments, next state is SETUP.
  - Otherwise: done = 1, next state is IDLE.
- mem_r_w and mem_addr change only while mem_oe = 0.
- mem_rdata is never sampled outside STROBE; Z or X on mem_rdata elsewhere has no effect.
- req asserted while busy=1 is ignored. It is not queued.
- Reset values: state IDLE; busy, rvalid, done, mem_oe and mem_r_w = 0; mem_addr, mem_wdata and rdata = 0.
- Reset mid-operation: mem_oe and mem_r_w drop to 0 immediately (asynchronously). No done or rvalid is produced. RAM content at an address written with mem_oe already high is unspecified.

## Timing
- All outputs are registered or decoded from registered state only. There are no combinational paths from inputs to outputs.
- With STROBE_CYCLES=2 and req sampled at edge 0:
  - cycle 1 SETUP
  - cycles 2–3 STROBE
  - cycle 4 RELEASE (rvalid/done)
  - cycle 5 IDLE
- Per word: 2 + STROBE_CYCLES cycles. A read burst of N words takes N·(2+STROBE_CYCLES) cycles with no idle gap between words.
- Earliest next acceptance is the first IDLE cycle after done; req held high through done is accepted there.

## Structure
- Shared package mem_if_pkg holds:
  - the DATA_W and ADDR_W defaults
  - the state enum {IDLE, SETUP, STROBE, RELEASE}
  - the localparam for the strobe counter width, $clog2(STROBE_CYCLES+1)
- No sub-module is needed. The FSM, strobe counter and word counter are inline.
- The bench pairs the DUT with the team's 4×8 RAM block, preloaded with 01, 03, 03, 04.

## Test plan
- Reset, then read burst addr=0 len=3 → four rvalid pulses, 4 cycles apart, rdata 0x01, 0x03, 0x03, 0x04; done with the 4th pulse; busy high for 16 cycles.
- Write addr=2 wdata=0xA5, then read addr=2 len=0 → mem_oe high in exactly 2 cycles with mem_r_w=1 already stable; rdata=0xA5; one done per transaction.
- Wrap: read addr=3 len=1 → mem_addr sequence 3, 0; rdata 0x04, then 0x01.
- req pulsed mid-burst with we=1 addr=1 → ignored; no write occurs; address 1 still reads 0x03 afterwards.
- rst_n low during STROBE of a read → mem_oe=0 asynchronously, busy=0, no rvalid or done; the next read of addr=0 returns 0x01.
- Checker on every cycle: mem_addr and mem_r_w never change while mem_oe=1; done is never asserted without a preceding accept.
